// File: rtl/rsa_exp_ctrl.sv
// RSA modular exponentiation sequencer: LSB-first square-and-multiply over
// a shared Montgomery multiplier, with one pre-processing pass per operation.
module rsa_exp_ctrl #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] N_i,
    input  logic [WIDTH-1:0] M_i,
    input  logic [WIDTH-1:0] e_i,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] result_o,
    output logic             prep_start,
    output logic [WIDTH-1:0] prep_N,
    output logic [WIDTH-1:0] prep_M,
    input  logic             prep_done,
    input  logic [WIDTH-1:0] prep_T,
    output logic             mont_start,
    output logic [WIDTH-1:0] mont_a,
    output logic [WIDTH-1:0] mont_b,
    output logic [WIDTH-1:0] mont_N,
    input  logic             mont_done,
    input  logic [WIDTH-1:0] mont_r
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        BIT,
        MUL,
        SQR,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] msg_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] t_q;
    logic [CNT_W-1:0] i_q;

    logic prep_ok;
    logic mont_ok;
    logic accept;
    logic t_from_prep;
    logic mul_go;
    logic sqr_go;
    logic m_from_mont;
    logic t_from_mont;
    logic step;
    logic fin_go;

    // A done coinciding with our own start pulse belongs to a stale request.
    assign prep_ok = prep_done && !prep_start;
    assign mont_ok = mont_done && !mont_start;

    assign busy   = (state != IDLE);
    assign prep_N = n_q;
    assign prep_M = msg_q;
    assign mont_N = n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        t_from_prep = 1'b0;
        mul_go      = 1'b0;
        sqr_go      = 1'b0;
        m_from_mont = 1'b0;
        t_from_mont = 1'b0;
        step        = 1'b0;
        fin_go      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (prep_ok) begin
                    t_from_prep = 1'b1;
                    state_d     = BIT;
                end
            end
            BIT: begin
                if (e_q[0]) begin
                    mul_go  = 1'b1;
                    state_d = MUL;
                end else begin
                    sqr_go  = 1'b1;
                    state_d = SQR;
                end
            end
            // Clearing the consumed bit lets BIT issue the square next.
            MUL: begin
                if (mont_ok) begin
                    m_from_mont = 1'b1;
                    state_d     = BIT;
                end
            end
            SQR: begin
                if (mont_ok) begin
                    t_from_mont = 1'b1;
                    if (i_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        step    = 1'b1;
                        state_d = BIT;
                    end
                end
            end
            DONE: begin
                fin_go  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prep_start <= 1'b0;
            mont_start <= 1'b0;
            finish     <= 1'b0;
            result_o   <= '0;
            mont_a     <= '0;
            mont_b     <= '0;
            n_q        <= '0;
            msg_q      <= '0;
            e_q        <= '0;
            m_q        <= '0;
            t_q        <= '0;
            i_q        <= '0;
        end else begin
            prep_start <= accept;
            mont_start <= mul_go || sqr_go;
            finish     <= fin_go;
            if (accept) begin
                n_q   <= N_i;
                msg_q <= M_i;
                e_q   <= e_i;
                m_q   <= WIDTH'(1);
                i_q   <= '0;
            end
            if (t_from_prep) begin
                t_q <= prep_T;
            end
            if (mul_go) begin
                mont_a <= m_q;
                mont_b <= t_q;
            end
            if (sqr_go) begin
                mont_a <= t_q;
                mont_b <= t_q;
            end
            if (m_from_mont) begin
                m_q    <= mont_r;
                e_q[0] <= 1'b0;
            end
            if (t_from_mont) begin
                t_q <= mont_r;
            end
            if (step) begin
                i_q <= i_q + CNT_W'(1);
                e_q <= e_q >> 1;
            end
            if (fin_go) begin
                result_o <= m_q;
            end
        end
    end

endmodule
